// File: rtl/sr_cmd_seq_pkg.sv
// Shared encodings and helpers for the sr_ff command sequencer.
// Holds op/state encodings and the switch for the S/R exclusivity assertion.
package sr_cmd_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SET = 2'b01,
        OP_CLR = 2'b10,
        OP_TGL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10
    } state_e;

    localparam bit SR_EXCL_CHECK = 1'b1;

    // TOGGLE collapses to whichever drive actually changes the current Q.
    function automatic op_e resolve_op(input op_e op, input logic q);
        if (op == OP_TGL) begin
            return q ? OP_CLR : OP_SET;
        end
        return op;
    endfunction

    function automatic logic expected_q(input op_e op);
        return (op == OP_SET);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that flags the last cycle of a PULSE_CYC-long pulse.
// Kept independent of the sequencer so later stages can reuse it.
module sr_pulse_timer #(
    parameter int PULSE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = (PULSE_CYC < 2) ? 1 : $clog2(PULSE_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(PULSE_CYC);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));

endmodule

// File: rtl/sr_cmd_seq.sv
// Command sequencer for sr_ff: turns SET/CLR/TOGGLE requests into exclusive
// S/R pulses, verifies Q afterwards and keeps sticky error and event counts.
module sr_cmd_seq
    import sr_cmd_seq_pkg::*;
#(
    parameter int PULSE_CYC = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic             err_clr,
    input  logic             q_fb,
    output logic             S,
    output logic             R,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_op,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] clr_cnt
);

    state_e state;
    op_e    op_q;
    op_e    req_op;
    logic   accept;
    logic   pulse_load;
    logic   pulse_done;
    logic   mismatch;

    assign cmd_ready  = (state == ST_IDLE) && rst;
    assign busy       = (state != ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign req_op     = resolve_op(op_e'(cmd_op), q_fb);
    assign pulse_load = accept && (req_op != OP_NOP);
    assign mismatch   = (state == ST_CHECK) && (q_fb != expected_q(op_q));

    sr_pulse_timer #(
        .PULSE_CYC (PULSE_CYC)
    ) u_pulse_timer (
        .clk  (clk),
        .rst  (rst),
        .load (pulse_load),
        .en   (state == ST_DRIVE),
        .done (pulse_done)
    );

    // S and R only ever rise from IDLE on distinct branches, so they cannot overlap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_NOP;
            S       <= 1'b0;
            R       <= 1'b0;
            err     <= 1'b0;
            err_op  <= 2'b00;
            set_cnt <= '0;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (req_op == OP_SET)) begin
                        op_q    <= OP_SET;
                        S       <= 1'b1;
                        set_cnt <= set_cnt + CNT_W'(1);
                        state   <= ST_DRIVE;
                    end else if (accept && (req_op == OP_CLR)) begin
                        op_q    <= OP_CLR;
                        R       <= 1'b1;
                        clr_cnt <= clr_cnt + CNT_W'(1);
                        state   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (pulse_done) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    S     <= 1'b0;
                    R     <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase

            // A fresh mismatch outranks a simultaneous clear request.
            if (mismatch) begin
                err    <= 1'b1;
                err_op <= op_q;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    generate
        if (SR_EXCL_CHECK) begin : g_sr_excl
            sr_never_both : assert property (@(posedge clk) !(S && R));
        end
    endgenerate

endmodule

// File: tb/tb_sr_cmd_seq.sv
// Bench for sr_cmd_seq driving a behavioural sr_ff; table-driven main sequence
// plus hand-written sequences for long pulses, counter wrap and mid-pulse reset.
module tb_sr_cmd_seq;

    typedef struct {
        logic       valid;
        logic [1:0] op;
        logic       eclr;
        logic [1:0] qf;
        logic       exp_s;
        logic       exp_r;
        logic       exp_busy;
        logic       exp_ready;
        logic       exp_err;
        logic [1:0] exp_eop;
        logic [7:0] exp_set;
        logic [7:0] exp_clr;
    } vec_t;

    logic       clk;
    logic       rst;

    logic       cmd_valid, cmd_ready, err_clr, q_fb, s1, r1, busy, err;
    logic [1:0] cmd_op, err_op, q_force;
    logic [7:0] set_cnt, clr_cnt;
    logic       q1;

    logic       cmd_valid3, cmd_ready3, q_fb3, s3, r3, busy3, err3;
    logic [1:0] cmd_op3, err_op3, set_cnt3, clr_cnt3;
    logic       q3;

    int checks;
    int errors;
    vec_t vecs[25];
    int pat_s[5];
    int pat_b[5];
    int pat_r[5];

    sr_cmd_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_ready (cmd_ready),
        .err_clr   (err_clr),
        .q_fb      (q_fb),
        .S         (s1),
        .R         (r1),
        .busy      (busy),
        .err       (err),
        .err_op    (err_op),
        .set_cnt   (set_cnt),
        .clr_cnt   (clr_cnt)
    );

    sr_cmd_seq #(
        .PULSE_CYC (3),
        .CNT_W     (2)
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid3),
        .cmd_op    (cmd_op3),
        .cmd_ready (cmd_ready3),
        .err_clr   (1'b0),
        .q_fb      (q_fb3),
        .S         (s3),
        .R         (r3),
        .busy      (busy3),
        .err       (err3),
        .err_op    (err_op3),
        .set_cnt   (set_cnt3),
        .clr_cnt   (clr_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sr_ff models; q_force lets a CHECK cycle see a wrong Q.
    always @(posedge clk) begin
        if (!rst) q1 <= 1'b0;
        else if (s1 && !r1) q1 <= 1'b1;
        else if (r1 && !s1) q1 <= 1'b0;
    end

    always @(posedge clk) begin
        if (!rst) q3 <= 1'b0;
        else if (s3 && !r3) q3 <= 1'b1;
        else if (r3 && !s3) q3 <= 1'b0;
    end

    assign q_fb  = (q_force == 2'd1) ? 1'b0 : (q_force == 2'd2) ? 1'b1 : q1;
    assign q_fb3 = q3;

    function automatic vec_t mk(input logic v, input logic [1:0] op, input logic ec,
                                input logic [1:0] qf, input logic es, input logic er,
                                input logic eb, input logic erdy, input logic ee,
                                input logic [1:0] eop, input logic [7:0] sc,
                                input logic [7:0] cc);
        vec_t t;
        t.valid = v;    t.op = op;          t.eclr = ec;       t.qf = qf;
        t.exp_s = es;   t.exp_r = er;       t.exp_busy = eb;   t.exp_ready = erdy;
        t.exp_err = ee; t.exp_eop = eop;    t.exp_set = sc;    t.exp_clr = cc;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cmd_valid = v.valid;
        cmd_op    = v.op;
        err_clr   = v.eclr;
        q_force   = v.qf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; err_clr = 1'b0; q_force = 2'd0;
        cmd_valid3 = 1'b0; cmd_op3 = 2'b00;

        //              v  op     ec qf  S  R  bsy rdy err eop    set clr
        vecs[0]  = mk(1, 2'b01, 0, 0, 1, 0, 1, 0, 0, 2'b00, 1, 0);
        vecs[1]  = mk(1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 0);
        vecs[2]  = mk(0, 2'b10, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 0);
        vecs[3]  = mk(1, 2'b11, 0, 0, 0, 1, 1, 0, 0, 2'b00, 1, 1);
        vecs[4]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 1, 1);
        vecs[5]  = mk(0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 2'b00, 1, 1);
        vecs[6]  = mk(1, 2'b11, 0, 0, 1, 0, 1, 0, 0, 2'b00, 2, 1);
        vecs[7]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2, 1);
        vecs[8]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2, 1);
        vecs[9]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2, 1);
        vecs[10] = mk(1, 2'b01, 0, 0, 1, 0, 1, 0, 0, 2'b00, 3, 1);
        vecs[11] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 3, 1);
        vecs[12] = mk(0, 2'b00, 0, 1, 0, 0, 0, 1, 1, 2'b01, 3, 1);
        vecs[13] = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b01, 3, 1);
        vecs[14] = mk(1, 2'b10, 0, 0, 0, 1, 1, 0, 1, 2'b01, 3, 2);
        vecs[15] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b01, 3, 2);
        vecs[16] = mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 2'b01, 3, 2);
        vecs[17] = mk(1, 2'b01, 0, 0, 1, 0, 1, 0, 1, 2'b01, 4, 2);
        vecs[18] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 2'b01, 4, 2);
        vecs[19] = mk(0, 2'b00, 1, 1, 0, 0, 0, 1, 1, 2'b01, 4, 2);
        vecs[20] = mk(0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 2'b01, 4, 2);
        vecs[21] = mk(1, 2'b10, 0, 0, 0, 1, 1, 0, 0, 2'b01, 4, 3);
        vecs[22] = mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b01, 4, 3);
        vecs[23] = mk(0, 2'b00, 0, 2, 0, 0, 0, 1, 1, 2'b10, 4, 3);
        vecs[24] = mk(0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 2'b10, 4, 3);

        pat_s = '{1, 1, 1, 0, 0};
        pat_b = '{1, 1, 1, 1, 0};
        pat_r = '{0, 0, 0, 0, 1};

        // Reset: held low for two edges, then released.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("ready_in_reset", {7'd0, cmd_ready}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_S", {7'd0, s1}, 8'd0);
        checkOutput("rst_R", {7'd0, r1}, 8'd0);
        checkOutput("rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("rst_ready", {7'd0, cmd_ready}, 8'd1);
        checkOutput("rst_err", {7'd0, err}, 8'd0);
        checkOutput("rst_err_op", {6'd0, err_op}, 8'd0);
        checkOutput("rst_set_cnt", set_cnt, 8'd0);
        checkOutput("rst_clr_cnt", clr_cnt, 8'd0);
        checkOutput("rst_ready3", {7'd0, cmd_ready3}, 8'd1);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d_S", i), {7'd0, s1}, {7'd0, vecs[i].exp_s});
            checkOutput($sformatf("row%0d_R", i), {7'd0, r1}, {7'd0, vecs[i].exp_r});
            checkOutput($sformatf("row%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].exp_busy});
            checkOutput($sformatf("row%0d_ready", i), {7'd0, cmd_ready}, {7'd0, vecs[i].exp_ready});
            checkOutput($sformatf("row%0d_err", i), {7'd0, err}, {7'd0, vecs[i].exp_err});
            checkOutput($sformatf("row%0d_err_op", i), {6'd0, err_op}, {6'd0, vecs[i].exp_eop});
            checkOutput($sformatf("row%0d_set_cnt", i), set_cnt, vecs[i].exp_set);
            checkOutput($sformatf("row%0d_clr_cnt", i), clr_cnt, vecs[i].exp_clr);
        end
        @(negedge clk);
        cmd_valid = 1'b0; err_clr = 1'b0; q_force = 2'd0;

        // Three-cycle pulses, five back-to-back SETs, 2-bit counter wraps.
        cmd_valid3 = 1'b1;
        cmd_op3    = 2'b01;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("p3_c%0d_S", c), {7'd0, s3}, 8'(pat_s[c % 5]));
            checkOutput($sformatf("p3_c%0d_R", c), {7'd0, r3}, 8'd0);
            checkOutput($sformatf("p3_c%0d_busy", c), {7'd0, busy3}, 8'(pat_b[c % 5]));
            checkOutput($sformatf("p3_c%0d_ready", c), {7'd0, cmd_ready3}, 8'(pat_r[c % 5]));
            if (c == 15) checkOutput("p3_set_cnt_wrap0", {6'd0, set_cnt3}, 8'd0);
        end
        @(negedge clk);
        cmd_valid3 = 1'b0;
        checkOutput("p3_set_cnt_final", {6'd0, set_cnt3}, 8'd1);
        checkOutput("p3_clr_cnt_final", {6'd0, clr_cnt3}, 8'd0);
        checkOutput("p3_err", {7'd0, err3}, 8'd0);

        // Reset arriving while S is being driven discards the command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_S_before", {7'd0, s1}, 8'd1);
        checkOutput("mid_rst_set_before", set_cnt, 8'd5);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_S", {7'd0, s1}, 8'd0);
        checkOutput("mid_rst_busy", {7'd0, busy}, 8'd0);
        checkOutput("mid_rst_ready_low", {7'd0, cmd_ready}, 8'd0);
        checkOutput("mid_rst_set_cnt", set_cnt, 8'd0);
        checkOutput("mid_rst_clr_cnt", clr_cnt, 8'd0);
        checkOutput("mid_rst_err_op", {6'd0, err_op}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_ready_after", {7'd0, cmd_ready}, 8'd1);

        // Clean restart after the aborted command.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("restart_set_cnt", set_cnt, 8'd1);
        checkOutput("restart_err", {7'd0, err}, 8'd0);
        checkOutput("restart_ready", {7'd0, cmd_ready}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
